// File: rtl/mem_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and arbitrates the memory port with an external requester.
module mem_seq_ctrl #(
   parameter int unsigned FETCH_WAIT = 0,
   parameter int unsigned MEM_WAIT   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr_in,
   input  logic       ext_req,
   input  logic       ext_we,
   output logic       ext_gnt,
   output logic       ir_we,
   output logic [2:0] opcode,
   output logic [1:0] mem_sel,
   output logic       memWE,
   output logic       regWE,
   output logic       lw,
   output logic       accWE,
   output logic       acc_sc,
   output logic [1:0] cntr_alu,
   output logic       brnch,
   output logic       pc_inc,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_GRANT  = 3'd5
   } state_t;

   localparam logic [2:0] FETCH_LAST_C = 3'(FETCH_WAIT);
   localparam logic [2:0] MEM_LAST_C   = 3'(MEM_WAIT);
   localparam logic [2:0] OP_LW        = 3'b100;
   localparam logic [2:0] OP_SW        = 3'b101;
   localparam logic [2:0] OP_LDI       = 3'b110;
   localparam logic [2:0] OP_BR        = 3'b111;
   localparam logic [1:0] SEL_PC       = 2'd0;
   localparam logic [1:0] SEL_ACC      = 2'd1;
   localparam logic [1:0] SEL_EXT      = 2'd2;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] wait_cnt_r;
   logic [2:0] opcode_r;
   state_t     boundary_nxt_s;
   logic       unused_imm_s;

   // The immediate field is consumed by the datapath, not by the sequencer.
   assign unused_imm_s   = ^instr_in[4:0];
   assign boundary_nxt_s = ext_req ? ST_GRANT : ST_FETCH;
   assign state          = state_r;
   assign opcode         = opcode_r;

   // Next-state and strobe decode from registered state, opcode and wait counter.
   always_comb begin
      state_nxt_s = state_r;
      ext_gnt     = 1'b0;
      ir_we       = 1'b0;
      mem_sel     = SEL_PC;
      memWE       = 1'b0;
      regWE       = 1'b0;
      lw          = 1'b0;
      accWE       = 1'b0;
      acc_sc      = 1'b0;
      cntr_alu    = opcode_r[1:0];
      brnch       = 1'b0;
      pc_inc      = 1'b0;
      // Strobes are forced low for as long as reset is held, not just at the edge.
      if (rst) begin
         state_nxt_s = ST_FETCH;
         cntr_alu    = 2'b00;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (wait_cnt_r >= FETCH_LAST_C) begin
                  ir_we       = 1'b1;
                  state_nxt_s = ST_DECODE;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end
            ST_DECODE: begin
               if ((opcode_r == OP_LW) || (opcode_r == OP_SW)) begin
                  state_nxt_s = ST_MEM;
               end else begin
                  state_nxt_s = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (opcode_r == OP_BR) begin
                  brnch = 1'b1;
               end else if (opcode_r == OP_LDI) begin
                  accWE  = 1'b1;
                  acc_sc = 1'b1;
                  pc_inc = 1'b1;
               end else begin
                  regWE  = ~opcode_r[2];
                  pc_inc = 1'b1;
               end
               state_nxt_s = boundary_nxt_s;
            end
            ST_MEM: begin
               mem_sel = SEL_ACC;
               if (wait_cnt_r >= MEM_LAST_C) begin
                  if (opcode_r == OP_SW) begin
                     memWE       = 1'b1;
                     pc_inc      = 1'b1;
                     state_nxt_s = boundary_nxt_s;
                  end else begin
                     state_nxt_s = ST_WB;
                  end
               end else begin
                  state_nxt_s = ST_MEM;
               end
            end
            ST_WB: begin
               mem_sel     = SEL_ACC;
               regWE       = 1'b1;
               lw          = 1'b1;
               pc_inc      = 1'b1;
               state_nxt_s = boundary_nxt_s;
            end
            ST_GRANT: begin
               ext_gnt     = 1'b1;
               mem_sel     = SEL_EXT;
               memWE       = ext_we;
               state_nxt_s = ext_req ? ST_GRANT : ST_FETCH;
            end
            default: begin
               state_nxt_s = ST_FETCH;
            end
         endcase
      end
   end

   // State register; the wait counter restarts on every state change and saturates at 7.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_FETCH;
         wait_cnt_r <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         if (state_nxt_s != state_r) begin
            wait_cnt_r <= 3'd0;
         end else if (wait_cnt_r != 3'd7) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // Opcode is captured together with the instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_r <= 3'd0;
      end else if (ir_we) begin
         opcode_r <= instr_in[7:5];
      end else begin
         opcode_r <= opcode_r;
      end
   end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: three instances with different wait settings share
// stimulus; each expected cycle is queued with the instance it targets and checked by a monitor.
module tb_mem_seq_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] instr_in;
   logic       ext_req;
   logic       ext_we;

   // Strobe bits, in order: ext_gnt ir_we memWE regWE lw accWE acc_sc brnch pc_inc
   localparam logic [8:0] S_NONE = 9'b000000000;
   localparam logic [8:0] S_GNT  = 9'b100000000;
   localparam logic [8:0] S_IR   = 9'b010000000;
   localparam logic [8:0] S_MWE  = 9'b001000000;
   localparam logic [8:0] S_RWE  = 9'b000100000;
   localparam logic [8:0] S_LW   = 9'b000010000;
   localparam logic [8:0] S_AWE  = 9'b000001000;
   localparam logic [8:0] S_ASC  = 9'b000000100;
   localparam logic [8:0] S_BR   = 9'b000000010;
   localparam logic [8:0] S_PCI  = 9'b000000001;

   logic       gnt0, irw0, mwe0, rwe0, lw0, awe0, asc0, br0, pci0;
   logic       gnt1, irw1, mwe1, rwe1, lw1, awe1, asc1, br1, pci1;
   logic       gnt2, irw2, mwe2, rwe2, lw2, awe2, asc2, br2, pci2;
   logic [2:0] op0, op1, op2, st0, st1, st2;
   logic [1:0] sel0, sel1, sel2, alu0, alu1, alu2;

   mem_seq_ctrl #(.FETCH_WAIT(0), .MEM_WAIT(0)) u0 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .ext_req(ext_req), .ext_we(ext_we),
      .ext_gnt(gnt0), .ir_we(irw0), .opcode(op0), .mem_sel(sel0), .memWE(mwe0),
      .regWE(rwe0), .lw(lw0), .accWE(awe0), .acc_sc(asc0), .cntr_alu(alu0),
      .brnch(br0), .pc_inc(pci0), .state(st0));

   mem_seq_ctrl #(.FETCH_WAIT(0), .MEM_WAIT(2)) u1 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .ext_req(ext_req), .ext_we(ext_we),
      .ext_gnt(gnt1), .ir_we(irw1), .opcode(op1), .mem_sel(sel1), .memWE(mwe1),
      .regWE(rwe1), .lw(lw1), .accWE(awe1), .acc_sc(asc1), .cntr_alu(alu1),
      .brnch(br1), .pc_inc(pci1), .state(st1));

   mem_seq_ctrl #(.FETCH_WAIT(1), .MEM_WAIT(0)) u2 (
      .clk(clk), .rst(rst), .instr_in(instr_in), .ext_req(ext_req), .ext_we(ext_we),
      .ext_gnt(gnt2), .ir_we(irw2), .opcode(op2), .mem_sel(sel2), .memWE(mwe2),
      .regWE(rwe2), .lw(lw2), .accWE(awe2), .acc_sc(asc2), .cntr_alu(alu2),
      .brnch(br2), .pc_inc(pci2), .state(st2));

   logic [18:0] obs0, obs1, obs2;
   assign obs0 = {st0, gnt0, irw0, op0, sel0, mwe0, rwe0, lw0, awe0, asc0, alu0, br0, pci0};
   assign obs1 = {st1, gnt1, irw1, op1, sel1, mwe1, rwe1, lw1, awe1, asc1, alu1, br1, pci1};
   assign obs2 = {st2, gnt2, irw2, op2, sel2, mwe2, rwe2, lw2, awe2, asc2, alu2, br2, pci2};

   typedef struct {
      string       nm;
      int          k;
      logic [18:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   checks;
   int   failures;
   event sample_ev;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string nm, input int k, input logic [2:0] st,
                           input logic [2:0] op, input logic [1:0] sel,
                           input logic [1:0] calu, input logic [8:0] s);
      exp_t e;
      e.nm = nm;
      e.k  = k;
      e.v  = {st, s[8], s[7], op, sel, s[6], s[5], s[4], s[3], s[2], calu, s[1], s[0]};
      sb_q.push_back(e);
   endtask

   // Asserts rst between edges, checks the immediate effect and the held state on all instances.
   task automatic apply_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) push_exp("rst_async", k, 3'd0, 3'd0, 2'd0, 2'd0, S_NONE);
      -> sample_ev;
      step();
      push_exp("rst_hold", 0, 3'd0, 3'd0, 2'd0, 2'd0, S_NONE);
      step();
      push_exp("rst_hold2", 0, 3'd0, 3'd0, 2'd0, 2'd0, S_NONE);
      step();
   endtask

   // Monitor: compares every queued expectation against the instance it names.
   initial begin
      checks   = 0;
      failures = 0;
      forever begin
         @(negedge clk or sample_ev);
         while (sb_q.size() > 0) begin
            exp_t        e;
            logic [18:0] obs;
            e = sb_q.pop_front();
            case (e.k)
               0:       obs = obs0;
               1:       obs = obs1;
               default: obs = obs2;
            endcase
            checks++;
            if (obs !== e.v) begin
               failures++;
               $display("FAIL %s (inst %0d): got %b expected %b", e.nm, e.k, obs, e.v);
            end
         end
      end
   end

   initial begin
      logic [3:0] we_pat;
      rst      = 1'b1;
      instr_in = 8'h00;
      ext_req  = 1'b0;
      ext_we   = 1'b0;
      we_pat   = 4'b1101;
      apply_reset();

      // ALU or, branch, ldi, then an add interrupted by reset in EXEC (waits 0)
      instr_in = 8'b011_00011;
      rst      = 1'b0;
      push_exp("alu_fetch",  0, 3'd0, 3'd0, 2'd0, 2'b00, S_IR);         step();
      push_exp("alu_decode", 0, 3'd1, 3'd3, 2'd0, 2'b11, S_NONE);       step();
      push_exp("alu_exec",   0, 3'd2, 3'd3, 2'd0, 2'b11, S_RWE | S_PCI); step();
      instr_in = 8'b111_00000;
      push_exp("br_fetch",   0, 3'd0, 3'd3, 2'd0, 2'b11, S_IR);         step();
      push_exp("br_decode",  0, 3'd1, 3'd7, 2'd0, 2'b11, S_NONE);       step();
      push_exp("br_exec",    0, 3'd2, 3'd7, 2'd0, 2'b11, S_BR);         step();
      instr_in = 8'b110_11111;
      push_exp("ldi_fetch",  0, 3'd0, 3'd7, 2'd0, 2'b11, S_IR);         step();
      push_exp("ldi_decode", 0, 3'd1, 3'd6, 2'd0, 2'b10, S_NONE);       step();
      push_exp("ldi_exec",   0, 3'd2, 3'd6, 2'd0, 2'b10, S_AWE | S_ASC | S_PCI); step();
      instr_in = 8'b001_00001;
      push_exp("add_fetch",  0, 3'd0, 3'd6, 2'd0, 2'b10, S_IR);         step();
      push_exp("add_decode", 0, 3'd1, 3'd1, 2'd0, 2'b01, S_NONE);       step();
      push_exp("add_exec",   0, 3'd2, 3'd1, 2'd0, 2'b01, S_RWE | S_PCI);
      apply_reset();

      // lw with MEM_WAIT=2: three MEM cycles, then WB
      instr_in = 8'b100_00001;
      rst      = 1'b0;
      push_exp("lw_fetch",  1, 3'd0, 3'd0, 2'd0, 2'b00, S_IR);   step();
      push_exp("lw_decode", 1, 3'd1, 3'd4, 2'd0, 2'b00, S_NONE); step();
      for (int i = 0; i < 3; i++) begin
         push_exp("lw_mem", 1, 3'd3, 3'd4, 2'd1, 2'b00, S_NONE);
         step();
      end
      push_exp("lw_wb",         1, 3'd4, 3'd4, 2'd1, 2'b00, S_RWE | S_LW | S_PCI); step();
      push_exp("lw_next_fetch", 1, 3'd0, 3'd4, 2'd0, 2'b00, S_IR);
      apply_reset();

      // sw with FETCH_WAIT=1; ext_we held high must not leak into memWE
      instr_in = 8'b101_00010;
      ext_we   = 1'b1;
      rst      = 1'b0;
      push_exp("sw_fetch0",     2, 3'd0, 3'd0, 2'd0, 2'b00, S_NONE);        step();
      push_exp("sw_fetch1",     2, 3'd0, 3'd0, 2'd0, 2'b00, S_IR);          step();
      push_exp("sw_decode",     2, 3'd1, 3'd5, 2'd0, 2'b01, S_NONE);        step();
      push_exp("sw_mem",        2, 3'd3, 3'd5, 2'd1, 2'b01, S_MWE | S_PCI); step();
      push_exp("sw_next_fetch", 2, 3'd0, 3'd5, 2'd0, 2'b01, S_NONE);
      apply_reset();

      // Arbitration: request raised in DECODE of lw is granted only after WB
      ext_we   = 1'b0;
      instr_in = 8'b100_00111;
      rst      = 1'b0;
      push_exp("arb_fetch",  0, 3'd0, 3'd0, 2'd0, 2'b00, S_IR);   step();
      ext_req = 1'b1;
      push_exp("arb_decode", 0, 3'd1, 3'd4, 2'd0, 2'b00, S_NONE); step();
      push_exp("arb_mem",    0, 3'd3, 3'd4, 2'd1, 2'b00, S_NONE); step();
      push_exp("arb_wb",     0, 3'd4, 3'd4, 2'd1, 2'b00, S_RWE | S_LW | S_PCI); step();
      for (int i = 0; i < 4; i++) begin
         ext_we = we_pat[i];
         if (i == 3) ext_req = 1'b0;
         push_exp("arb_grant", 0, 3'd5, 3'd4, 2'd2, 2'b00, ext_we ? (S_GNT | S_MWE) : S_GNT);
         step();
      end
      push_exp("arb_release", 0, 3'd0, 3'd4, 2'd0, 2'b00, S_IR);
      step();

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
